fetch_unit: RTL and testbench

Byte-serial Y86-64 fetch stage for the sequential processor. It reads one instruction per request from a byte-wide instruction memory, starting at a supplied PC. It splits the instruction into icode, ifun, rA, rB and valC and computes valP and a status code. A one-cycle `f_com` completion pulse hands the fields to the decode stage, which consumes icode/rA/rB on that pulse.

---
 rtl/y86_pkg.sv | 32 +++
 rtl/instr_len_decode.sv | 60 ++++++
 rtl/fetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants: icodes, status codes, fetch states, register codes
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        F_IDLE  = 3'd0,
        F_BYTE0 = 3'd1,
        F_REGS  = 3'd2,
        F_CONST = 3'd3,
        F_DONE  = 3'd4
    } fetchState_e;

endpackage

// File: rtl/instr_len_decode.sv
// rtl/instr_len_decode.sv - icode/ifun legality and instruction length decode
module instr_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic       valid,
    output logic       need_regs,
    output logic       need_valC,
    output logic [3:0] len
);

    always_comb begin
        valid     = 1'b0;
        need_regs = 1'b0;
        need_valC = 1'b0;
        len       = 4'd0;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                valid = (ifun == 4'h0);
                len   = 4'd1;
            end
            I_RRMOVQ: begin
                valid     = (ifun <= 4'h6);
                need_regs = 1'b1;
                len       = 4'd2;
            end
            I_OPQ: begin
                valid     = (ifun <= 4'h3);
                need_regs = 1'b1;
                len       = 4'd2;
            end
            I_PUSHQ, I_POPQ: begin
                valid     = (ifun == 4'h0);
                need_regs = 1'b1;
                len       = 4'd2;
            end
            I_JXX: begin
                valid     = (ifun <= 4'h6);
                need_valC = 1'b1;
                len       = 4'd9;
            end
            I_CALL: begin
                valid     = (ifun == 4'h0);
                need_valC = 1'b1;
                len       = 4'd9;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                valid     = (ifun == 4'h0);
                need_regs = 1'b1;
                need_valC = 1'b1;
                len       = 4'd10;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte-serial Y86-64 fetch stage: FSM, address register, field registers, halted flag
module fetch_unit
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] pc_in,
    output logic [63:0] imem_addr,
    input  logic [7:0]  imem_rdata,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [2:0]  stat,
    output logic        f_com,
    output logic        busy
);

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

    fetchState_e state;
    logic [63:0] addrReg;
    logic [63:0] pcReg;
    logic [2:0]  byteIdx;
    logic        halted;

    logic [3:0]  decIcode;
    logic [3:0]  decIfun;
    logic        decValid;
    logic        decNeedRegs;
    logic        decNeedValC;
    logic [3:0]  decLen;
    logic        addrFault;
    logic [63:0] addrNext;
    logic [63:0] seqP;

    assign imem_addr = addrReg;
    assign addrFault = (addrReg >= MEM_LIMIT);
    assign addrNext  = addrReg + 64'd1;

    // In BYTE0 the opcode is still on the memory bus; afterwards it lives in icode/ifun.
    assign decIcode = (state == F_BYTE0) ? imem_rdata[7:4] : icode;
    assign decIfun  = (state == F_BYTE0) ? imem_rdata[3:0] : ifun;
    assign seqP     = pcReg + {60'd0, decLen};

    instr_len_decode u_len (
        .icode     (decIcode),
        .ifun      (decIfun),
        .valid     (decValid),
        .need_regs (decNeedRegs),
        .need_valC (decNeedValC),
        .len       (decLen)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= F_IDLE;
            addrReg <= '0;
            pcReg   <= '0;
            byteIdx <= '0;
            halted  <= 1'b0;
            icode   <= I_HALT;
            ifun    <= 4'h0;
            rA      <= RNONE;
            rB      <= RNONE;
            valC    <= '0;
            valP    <= '0;
            stat    <= S_AOK;
            f_com   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            f_com <= 1'b0;
            case (state)
                F_IDLE, F_DONE: begin
                    if (start && !halted) begin
                        addrReg <= pc_in;
                        pcReg   <= pc_in;
                        byteIdx <= '0;
                        icode   <= I_HALT;
                        ifun    <= 4'h0;
                        rA      <= RNONE;
                        rB      <= RNONE;
                        valC    <= '0;
                        valP    <= '0;
                        stat    <= S_AOK;
                        busy    <= 1'b1;
                        state   <= F_BYTE0;
                    end else begin
                        state <= F_IDLE;
                    end
                end
                F_BYTE0: begin
                    if (addrFault) begin
                        stat   <= S_ADR;
                        halted <= 1'b1;
                        valP   <= seqP;
                        f_com  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= F_DONE;
                    end else begin
                        icode <= imem_rdata[7:4];
                        ifun  <= imem_rdata[3:0];
                        if (!decValid) begin
                            stat   <= S_INS;
                            halted <= 1'b1;
                            valP   <= seqP;
                            f_com  <= 1'b1;
                            busy   <= 1'b0;
                            state  <= F_DONE;
                        end else begin
                            addrReg <= addrNext;
                            if (decLen == 4'd1) begin
                                if (imem_rdata[7:4] == I_HALT) begin
                                    stat   <= S_HLT;
                                    halted <= 1'b1;
                                end
                                valP  <= seqP;
                                f_com <= 1'b1;
                                busy  <= 1'b0;
                                state <= F_DONE;
                            end else if (decNeedRegs) begin
                                state <= F_REGS;
                            end else begin
                                state <= F_CONST;
                            end
                        end
                    end
                end
                F_REGS: begin
                    if (addrFault) begin
                        stat   <= S_ADR;
                        halted <= 1'b1;
                        valP   <= seqP;
                        f_com  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= F_DONE;
                    end else begin
                        rA      <= imem_rdata[7:4];
                        rB      <= imem_rdata[3:0];
                        addrReg <= addrNext;
                        if (decNeedValC) begin
                            state <= F_CONST;
                        end else begin
                            valP  <= seqP;
                            f_com <= 1'b1;
                            busy  <= 1'b0;
                            state <= F_DONE;
                        end
                    end
                end
                F_CONST: begin
                    // A fault mid-constant keeps whatever bytes were already captured.
                    if (addrFault) begin
                        stat   <= S_ADR;
                        halted <= 1'b1;
                        valP   <= seqP;
                        f_com  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= F_DONE;
                    end else begin
                        valC[{byteIdx, 3'b000} +: 8] <= imem_rdata;
                        addrReg <= addrNext;
                        byteIdx <= byteIdx + 3'd1;
                        if (byteIdx == 3'd7) begin
                            valP  <= seqP;
                            f_com <= 1'b1;
                            busy  <= 1'b0;
                            state <= F_DONE;
                        end
                    end
                end
                default: begin
                    state <= F_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a behavioural fetch model
module tb_fetch_unit;
    import y86_pkg::*;

    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] pc_in = '0;
    logic [63:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [2:0]  stat;
    logic        f_com, busy;

    logic [7:0] mem [0:MB-1];

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
        logic [2:0]  stat;
        int          lat;
        int          acceptCycle;
    } exp_t;

    exp_t sbq[$];
    exp_t monExp;
    int   nVec = 0;
    int   nErr = 0;
    int   cycle = 0;
    bit   modelHalted = 0;

    fetch_unit #(.MEM_BYTES(MB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pc_in      (pc_in),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .icode      (icode),
        .ifun       (ifun),
        .rA         (rA),
        .rB         (rB),
        .valC       (valC),
        .valP       (valP),
        .stat       (stat),
        .f_com      (f_com),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;
    always_comb imem_rdata = (imem_addr < 64'(MB)) ? mem[imem_addr[9:0]] : 8'h00;

    // Fetch as the ISA describes it: length by opcode, bytes walked from pc, first bad address aborts.
    function automatic exp_t refFetch(input logic [63:0] pc);
        exp_t        e;
        logic [63:0] a;
        logic [7:0]  b;
        int          len, maxFun, idx;
        e.icode = 4'h0; e.ifun = 4'h0; e.rA = 4'hF; e.rB = 4'hF;
        e.valC = '0; e.valP = '0; e.stat = S_AOK; e.lat = 1; e.acceptCycle = 0;
        if (pc >= 64'(MB)) begin
            e.stat = S_ADR;
            return e;
        end
        b = mem[pc[9:0]];
        e.icode = b[7:4];
        e.ifun  = b[3:0];
        case (int'(e.icode))
            0, 1, 9:        len = 1;
            2, 6, 10, 11:   len = 2;
            7, 8:           len = 9;
            3, 4, 5:        len = 10;
            default:        len = 0;
        endcase
        case (int'(e.icode))
            2, 7:    maxFun = 6;
            6:       maxFun = 3;
            default: maxFun = 0;
        endcase
        if (len == 0 || int'(e.ifun) > maxFun) begin
            e.stat = S_INS;
            return e;
        end
        e.valP = pc + 64'(len);
        if (len == 1) begin
            if (e.icode == 4'h0) e.stat = S_HLT;
            return e;
        end
        idx = 1;
        if (len == 2 || len == 10) begin
            a = pc + 64'd1;
            if (a >= 64'(MB)) begin
                e.stat = S_ADR;
                e.lat  = 2;
                return e;
            end
            e.rA = mem[a[9:0]][7:4];
            e.rB = mem[a[9:0]][3:0];
            idx = 2;
        end
        if (len >= 9) begin
            for (int k = 0; k < 8; k++) begin
                a = pc + 64'(idx + k);
                if (a >= 64'(MB)) begin
                    e.stat = S_ADR;
                    e.lat  = idx + k + 1;
                    return e;
                end
                e.valC[8*k +: 8] = mem[a[9:0]];
            end
        end
        e.lat = len;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && f_com) begin
            if (sbq.size() == 0) begin
                nVec++;
                nErr++;
                $display("FAIL unexpected_f_com: got 1 expected 0 (cycle %0d)", cycle);
            end else begin
                monExp = sbq.pop_front();
                check("icode", 64'(icode), 64'(monExp.icode));
                check("ifun", 64'(ifun), 64'(monExp.ifun));
                check("rA", 64'(rA), 64'(monExp.rA));
                check("rB", 64'(rB), 64'(monExp.rB));
                check("valC", valC, monExp.valC);
                check("stat", 64'(stat), 64'(monExp.stat));
                check("latency", 64'(cycle - monExp.acceptCycle), 64'(monExp.lat));
                check("busy_at_done", 64'(busy), 64'd0);
                if (monExp.stat == S_AOK || monExp.stat == S_HLT)
                    check("valP", valP, monExp.valP);
            end
        end
    end

    task automatic issue(input logic [63:0] pc);
        exp_t e;
        e = refFetch(pc);
        start = 1'b1;
        pc_in = pc;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!modelHalted) begin
            e.acceptCycle = cycle;
            sbq.push_back(e);
            check("busy_after_accept", 64'(busy), 64'd1);
            if (e.stat != S_AOK) modelHalted = 1;
        end
    endtask

    task automatic waitDone();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!f_com && n < 20);
        if (!f_com) begin
            nVec++;
            nErr++;
            $display("FAIL f_com_timeout: got 0 expected 1 within 20 cycles (cycle %0d)", cycle);
            sbq.delete();
        end
        #1;
    endtask

    task automatic checkResetValues();
        check("rst_icode", 64'(icode), 64'h0);
        check("rst_ifun", 64'(ifun), 64'h0);
        check("rst_rA", 64'(rA), 64'hF);
        check("rst_rB", 64'(rB), 64'hF);
        check("rst_valC", valC, 64'h0);
        check("rst_valP", valP, 64'h0);
        check("rst_stat", 64'(stat), 64'(S_AOK));
        check("rst_f_com", 64'(f_com), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_imem_addr", imem_addr, 64'h0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkResetValues();
        sbq.delete();
        modelHalted = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic ignoredStart();
        start = 1'b1;
        pc_in = 64'($urandom_range(0, 100));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("halted_busy", 64'(busy), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("halted_f_com", 64'(f_com), 64'd0);
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] pc;
        int r;

        for (int i = 0; i < MB; i++) begin
            if ($urandom_range(0, 3) == 0) mem[i] = 8'($urandom);
            else mem[i] = {4'($urandom_range(1, 11)), 4'h0};
        end
        mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h08;
        for (int i = 3; i < 10; i++) mem[i] = 8'h00;
        mem[10] = 8'h60; mem[11] = 8'h23; mem[12] = 8'h00;
        mem[20] = 8'h80; mem[21] = 8'h00; mem[22] = 8'h01;
        for (int i = 23; i < 29; i++) mem[i] = 8'h00;
        mem[1020] = 8'h30; mem[1021] = 8'hF3; mem[1022] = 8'h00; mem[1023] = 8'h00;

        repeat (2) @(negedge clk);
        checkResetValues();
        rst_n = 1'b1;
        @(negedge clk);

        // irmovq, with a stray start while busy that must be ignored
        issue(64'd0);
        @(negedge clk);
        start = 1'b1;
        pc_in = 64'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone();

        // back-to-back OPq then halt, then a start that must be ignored
        issue(64'd10);
        waitDone();
        issue(64'd12);
        waitDone();
        ignoredStart();
        doReset();

        issue(64'd20);
        waitDone();

        // reset during CONST of an irmovq, then a normal fetch
        issue(64'd0);
        repeat (3) @(negedge clk);
        doReset();
        repeat (12) @(negedge clk);
        check("no_f_com_after_abort", 64'(f_com), 64'd0);
        issue(64'd10);
        waitDone();

        mem[0] = 8'h27;
        issue(64'd0);
        waitDone();
        ignoredStart();
        doReset();

        issue(64'd1020);
        waitDone();
        doReset();

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 7);
            if (r < 6)       pc = 64'($urandom_range(0, 1019));
            else if (r == 6) pc = 64'($urandom_range(1010, 1023));
            else             pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            issue(pc);
            waitDone();
            if (modelHalted) begin
                if ($urandom_range(0, 3) == 0) ignoredStart();
                doReset();
            end else if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 2)) @(negedge clk);
                #1;
            end
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
